// File: rtl/pipeline_skid_register.sv
// Two-entry skid-buffer pipeline stage with valid/ready on both sides and fully registered backpressure.
// Optional saturating stall/drop counters are built when STAGE_REG_PERF_EN is defined.
module pipeline_skid_register #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef STAGE_REG_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] drop_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             acc_in;
    logic             acc_out;
    state_t           state;

    if (WIDTH < 1) begin : g_bad_width
        $error("WIDTH must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    // in_ready depends only on registered state and rst, never on out_ready.
    assign in_ready  = ~skid_valid & ~rst;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
    assign acc_in    = in_valid & in_ready;
    assign acc_out   = main_valid & out_ready;

    always_comb begin
        state = EMPTY;
        if (skid_valid) begin
            state = FULL;
        end else if (main_valid) begin
            state = ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= RST_VAL;
            skid_data  <= RST_VAL;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc_in) begin
                        main_valid <= 1'b1;
                        main_data  <= in_data;
                    end
                end
                ONE: begin
                    if (acc_in && acc_out) begin
                        main_data <= in_data;
                    end else if (acc_in) begin
                        skid_valid <= 1'b1;
                        skid_data  <= in_data;
                    end else if (acc_out) begin
                        main_valid <= 1'b0;
                    end
                end
                FULL: begin
                    // Skid word moves up; skid_data keeps its stale copy, masked by skid_valid.
                    if (acc_out) begin
                        main_data  <= skid_data;
                        skid_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef STAGE_REG_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]       drop_add;
    logic [CNT_W+1:0] drop_sum;

    assign drop_add = {1'b0, occupancy} + {2'b00, acc_in};
    assign drop_sum = {2'b00, drop_cnt} + (CNT_W+2)'(drop_add);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (main_valid && !out_ready && !flush && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush) begin
                drop_cnt <= (drop_sum > {2'b00, CNT_MAX}) ? CNT_MAX : drop_sum[CNT_W-1:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Directed plus random bench for pipeline_skid_register against a queue-based reference model.
module tb_pipeline_skid_register;
    localparam int               WIDTH   = 32;
    localparam int               CNT_W   = 4;
    localparam logic [WIDTH-1:0] RST_VAL = 32'hDEAD_0000;
    localparam int               CNT_MAX = (1 << CNT_W) - 1;
    localparam int               DEPTH   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
`ifdef STAGE_REG_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: the stage is a FIFO of capacity DEPTH whose contents are exp_q.
    logic [WIDTH-1:0] exp_q[$];
    bit               cleared;
    int               stall_exp;
    int               drop_exp;

    pipeline_skid_register #(
        .WIDTH  (WIDTH),
        .RST_VAL(RST_VAL),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
`ifdef STAGE_REG_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        cleared   = 1'b1;
        stall_exp = 0;
        drop_exp  = 0;
    endtask

    // One clock: drive inputs, check outputs against the model, then advance model and clock.
    task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                        input logic fl, input logic r, output bit accepted);
        int sz;
        bit acc_in;
        bit acc_out;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        #1;
        sz = exp_q.size();
        check("in_ready", 32'(in_ready), 32'(sz < DEPTH && !r));
        check("out_valid", 32'(out_valid), 32'(sz > 0));
        check("occupancy", 32'(occupancy), 32'(sz));
        if (sz > 0) begin
            check("out_data", out_data, exp_q[0]);
        end else if (cleared) begin
            check("out_data_rst", out_data, RST_VAL);
        end
`ifdef STAGE_REG_PERF_EN
        check("stall_cnt", 32'(stall_cnt), 32'(stall_exp));
        check("drop_cnt", 32'(drop_cnt), 32'(drop_exp));
`endif
        acc_in   = iv && sz < DEPTH && !r;
        acc_out  = sz > 0 && ordy;
        accepted = acc_in;
        if (r) begin
            stall_exp = 0;
            drop_exp  = 0;
        end else begin
            if (sz > 0 && !ordy && !fl) stall_exp = (stall_exp < CNT_MAX) ? stall_exp + 1 : CNT_MAX;
            if (fl) drop_exp = (drop_exp + sz + int'(acc_in) < CNT_MAX) ? drop_exp + sz + int'(acc_in) : CNT_MAX;
        end
        if (r || fl) begin
            exp_q.delete();
            cleared = 1'b1;
        end else begin
            if (acc_out) void'(exp_q.pop_front());
            if (acc_in) begin
                exp_q.push_back(id);
                cleared = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit               acc;
        logic             iv;
        logic [WIDTH-1:0] d;

        apply_reset();

        // Idle after reset: empty, RST_VAL on out_data, ready immediately.
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        // Streaming with out_ready high.
        step(1'b1, 32'h11, 1'b1, 1'b0, 1'b0, acc);
        step(1'b1, 32'h22, 1'b1, 1'b0, 1'b0, acc);
        step(1'b1, 32'h33, 1'b1, 1'b0, 1'b0, acc);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        // Backpressure: A3 must wait while FULL, then everything drains in order.
        step(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'hA3, 1'b0, 1'b0, 1'b0, acc);
        check("a3_held", 32'(acc), 32'(0));
        step(1'b1, 32'hA3, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'hA3, 1'b1, 1'b0, 1'b0, acc);
        step(1'b1, 32'hA3, 1'b1, 1'b0, 1'b0, acc);
        check("a3_accepted", 32'(acc), 32'(1));
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        // Flush while FULL with a word offered; B3 never appears.
        step(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'hB2, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'hB3, 1'b0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        // Flush in ONE with accept on both sides: D1 still seen downstream, D2 discarded.
        step(1'b1, 32'hD1, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'hD2, 1'b1, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        // Reset while FULL with a word offered.
        step(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 32'hC3, 1'b1, 1'b0, 1'b1, acc);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        // Long stall saturates the stall counter; a following flush must not clear it.
        step(1'b1, 32'hE1, 1'b0, 1'b0, 1'b0, acc);
        repeat (20) step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
`ifdef STAGE_REG_PERF_EN
        check("stall_saturated", 32'(stall_cnt), 32'(CNT_MAX));
`endif
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
`ifdef STAGE_REG_PERF_EN
        check("stall_after_flush", 32'(stall_cnt), 32'(CNT_MAX));
`endif

        // Random traffic; an offered word is held until accepted.
        iv  = 1'b0;
        d   = '0;
        acc = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!(iv && !acc)) begin
                iv = ($urandom_range(0, 3) != 0);
                d  = $urandom;
            end
            step(iv, d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 80) == 0), acc);
        end
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
